// File: rtl/bcd_seg_scan.sv
// Eight-digit multiplexed BCD to seven-segment scanner with a load-strobed shadow register.
// Define LEAD_ZERO_BLANK_EN to blank slots above the most significant nonzero digit.
module bcd_seg_scan #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter logic [7:0]  DP_MASK  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dec_in,
    input  logic        load,
    output logic        ld_ack,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // Active-low segment pattern for one BCD digit; non-decimal codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

`ifdef LEAD_ZERO_BLANK_EN
    // Highest slot holding a nonzero nibble; zero when the whole word is zero.
    function automatic logic [2:0] msd_index(input logic [31:0] v);
        logic [2:0] m;
        m = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i*4 +: 4] != 4'd0) begin
                m = 3'(i);
            end else begin
                m = m;
            end
        end
        return m;
    endfunction
`endif

    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    logic [2:0]       idx_r;
    logic [31:0]      shadow_r;
    logic             ld_ack_r;
    logic [7:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;

    logic [3:0]       digit_s;
    logic             blank_s;
    logic [7:0]       an_s;
    logic [6:0]       seg_s;
    logic             dp_s;

    assign tick_s = (div_r == DIV_LAST);

    // Slot-period divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Active digit index, advancing once per slot period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r <= 3'd0;
        end else if (tick_s) begin
            idx_r <= idx_r + 3'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Shadow capture and its one-cycle acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r <= 32'h0000_0000;
            ld_ack_r <= 1'b0;
        end else begin
            ld_ack_r <= load;
            if (load) begin
                shadow_r <= dec_in;
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    // Next display drive for the current slot.
    always_comb begin
        digit_s = shadow_r[{idx_r, 2'b00} +: 4];
`ifdef LEAD_ZERO_BLANK_EN
        blank_s = (idx_r > msd_index(shadow_r));
`else
        blank_s = 1'b0;
`endif
        if (blank_s) begin
            an_s  = 8'hFF;
            seg_s = 7'h7F;
            dp_s  = 1'b1;
        end else begin
            an_s  = ~(8'h01 << idx_r);
            seg_s = seg_decode(digit_s);
            dp_s  = ~DP_MASK[idx_r];
        end
    end

    // Registered display outputs; dark while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_r  <= 8'hFF;
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
            dp_r  <= dp_s;
        end
    end

    assign ld_ack = ld_ack_r;
    assign an     = an_r;
    assign seg    = seg_r;
    assign dp     = dp_r;

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 The block SHALL take parameter SCAN_DIV, default 100000: clock cycles per digit slot; legal range 1..2^20.
REQ-002 The block SHALL take parameter DP_MASK, default 8'h00: bit i set lights the decimal point on digit i.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; reset is asynchronous and active-low.
REQ-005 The block SHALL have port dec_in, input, 32, packed BCD; digit i in bits [4i+3:4i], digit 0 least significant.
REQ-006 The block SHALL have port load, input, 1, capture strobe for dec_in.
REQ-007 The block SHALL have port ld_ack, output, 1, capture acknowledge.
REQ-008 The block SHALL have port an, output, 8, digit enables, active-low, an[i] selects digit i.
REQ-009 The block SHALL have port seg, output, 7, segments, active-low, seg[0]=a ... seg[6]=g.
REQ-010 The block SHALL have port dp, output, 1, decimal point, active-low.

Function
REQ-011 Divider counter SHALL count 0..SCAN_DIV-1 and wrap; tick asserts in the cycle the count equals SCAN_DIV-1; SCAN_DIV=1 gives a tick every cycle.
REQ-012 Digit index (3 bits) SHALL advance by 1 on each tick and wrap 7->0.
REQ-013 Shadow register SHALL capture dec_in on every rising edge with load=1 and hold otherwise.
REQ-014 ld_ack SHALL be 1 in the cycle after each capture, 0 otherwise; load held high N cycles gives ld_ack high N cycles, delayed by 1.
REQ-015 an, seg and dp SHALL be registered, decoded from current index and shadow; a new value is visible on seg 1 cycle after capture if its digit is active.
REQ-016 an SHALL be ~(8'h01 << index) for every non-blanked slot.
REQ-017 seg decode SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex).
REQ-018 Digit values 10..15 SHALL display a dash, seg=7'h3F.
REQ-019 dp SHALL equal ~DP_MASK[index] for non-blanked slots and 1 for blanked slots.
REQ-020 A capture coinciding with a tick SHALL take effect; the next slot shows the new shadow value.

Reset
REQ-021 While rst=0, an=8'hFF, seg=7'h7F, dp=1, ld_ack=0, shadow=0, index=0 and divider=0, all immediately, independent of clk.
REQ-022 The first rising edge after rst deasserts SHALL drive an=8'hFE with digit 0 of the shadow; the scan restarts from index 0 regardless of state at reset.

Configuration
REQ-023 Macro LEAD_ZERO_BLANK_EN SHALL enable leading-zero blanking.
- Defined: slots above the most significant nonzero digit get an[i]=1, seg=7'h7F, dp=1.
- Digit 0 is never blanked; shadow=0 shows a single "0".
- A digit value 10..15 counts as nonzero.
REQ-024 With LEAD_ZERO_BLANK_EN undefined, all eight slots SHALL always be driven per REQ-016..REQ-019.

Verification (SCAN_DIV=4, DP_MASK=8'h00 unless stated)
REQ-025 rst=0 mid-scan at index 5 -> an=FF, seg=7F, dp=1 within the same cycle; after release, first edge gives an=FE and seg=40.
REQ-026 load 1 cycle with dec_in=32'h00012345 -> ld_ack=1 next cycle only; slots 0..4 show seg 12,19,30,24,79, each for 4 cycles.
- With blanking: slots 5..7 give an[i]=1, seg=7F.
- Without blanking: slots 5..7 show seg=40.
REQ-027 dec_in=32'h0000000A loaded -> slot 0 seg=3F; with blanking, slots 1..7 are blank.
REQ-028 dec_in=0 loaded with blanking -> only an=FE is ever asserted, seg=40; other slots an=FF.
REQ-029 load high 3 cycles with dec_in 11111111, 22222222, 33333333 -> ld_ack high 3 cycles; shadow=33333333; every slot shows seg=30.
REQ-030 SCAN_DIV=1, DP_MASK=8'h04 -> index changes every cycle; dp=0 only while an=FB.
